// File: rtl/maxpool2d.sv
// 2x2 stride-2 signed max pooling over a flattened CHANNELS x IMG_SIZE x IMG_SIZE map, one element per cycle.
// Optional MAXPOOL_ARGMAX_EN adds argmax_flat with the winning window position (k=0..3) per output.
module maxpool2d #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28
) (
  input  logic                                                              clk,
  input  logic                                                              reset,
  input  logic                                                              start,
  input  logic signed [DATA_WIDTH*CHANNELS*IMG_SIZE*IMG_SIZE-1:0]           in_feature_flat,
  output logic signed [DATA_WIDTH*CHANNELS*(IMG_SIZE/2)*(IMG_SIZE/2)-1:0]   out_feature_flat,
`ifdef MAXPOOL_ARGMAX_EN
  output logic        [2*CHANNELS*(IMG_SIZE/2)*(IMG_SIZE/2)-1:0]            argmax_flat,
`endif
  output logic                                                              busy,
  output logic                                                              done
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_RUN    | reading one window element per cycle
  // S_FINISH | pass complete, pulsing done
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam int OUT_SIZE = IMG_SIZE / 2;
  localparam int N_WIN    = CHANNELS * OUT_SIZE * OUT_SIZE;
  localparam int IN_BITS  = DATA_WIDTH * CHANNELS * IMG_SIZE * IMG_SIZE;
  localparam int IN_AW    = $clog2(IN_BITS);
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OS_W     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int WIN_W    = (N_WIN > 1) ? $clog2(N_WIN) : 1;

  logic [1:0]                   state;
  logic [CH_W-1:0]              ch;
  logic [OS_W-1:0]              orow;
  logic [OS_W-1:0]              ocol;
  logic [1:0]                   k;
  logic signed [DATA_WIDTH-1:0] cur_max;
  logic signed [DATA_WIDTH-1:0] elem;
  logic signed [DATA_WIDTH-1:0] win_max;
  logic                         take_new;
  logic [IN_AW-1:0]             rd_off;
  logic [WIN_W-1:0]             wr_idx;
  logic                         last_ocol;
  logic                         last_orow;
  logic                         last_ch;
  logic signed [DATA_WIDTH-1:0] out_mem [N_WIN];

  // Row/col of the current element come straight from the window counters, so an
  // odd trailing row/column is simply never addressed.
  always_comb begin
    rd_off    = IN_AW'(((32'(ch) * IMG_SIZE + 2 * 32'(orow) + 32'(k[1])) * IMG_SIZE
                        + 2 * 32'(ocol) + 32'(k[0])) * DATA_WIDTH);
    wr_idx    = WIN_W'((32'(ch) * OUT_SIZE + 32'(orow)) * OUT_SIZE + 32'(ocol));
    elem      = in_feature_flat[rd_off +: DATA_WIDTH];
    take_new  = (k == 2'd0) || (elem > cur_max);
    win_max   = take_new ? elem : cur_max;
    last_ocol = (ocol == OS_W'(OUT_SIZE - 1));
    last_orow = (orow == OS_W'(OUT_SIZE - 1));
    last_ch   = (ch == CH_W'(CHANNELS - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      ch      <= '0;
      orow    <= '0;
      ocol    <= '0;
      k       <= '0;
      cur_max <= '0;
      for (int i = 0; i < N_WIN; i++) out_mem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ch    <= '0;
            orow  <= '0;
            ocol  <= '0;
            k     <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          cur_max <= win_max;
          k       <= k + 2'd1;
          if (k == 2'd3) begin
            out_mem[wr_idx] <= win_max;
            if (last_ocol) begin
              ocol <= '0;
              if (last_orow) begin
                orow <= '0;
                if (last_ch) begin
                  ch    <= '0;
                  state <= S_FINISH;
                end else begin
                  ch <= ch + 1'b1;
                end
              end else begin
                orow <= orow + 1'b1;
              end
            end else begin
              ocol <= ocol + 1'b1;
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  for (genvar g = 0; g < N_WIN; g++) begin : g_out
    assign out_feature_flat[g*DATA_WIDTH +: DATA_WIDTH] = out_mem[g];
  end

`ifdef MAXPOOL_ARGMAX_EN
  logic [1:0] cur_am;
  logic [1:0] win_am;
  logic [1:0] am_mem [N_WIN];

  assign win_am = take_new ? k : cur_am;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_am <= '0;
      for (int i = 0; i < N_WIN; i++) am_mem[i] <= '0;
    end else if (state == S_RUN) begin
      cur_am <= win_am;
      if (k == 2'd3) am_mem[wr_idx] <= win_am;
    end
  end

  for (genvar g = 0; g < N_WIN; g++) begin : g_am
    assign argmax_flat[2*g +: 2] = am_mem[g];
  end
`endif

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: a 1x4x4 and a 2x5x5 instance, table vectors, corner sequences and random passes.
module tb_maxpool2d;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b;
  logic [DW*16-1:0] in_a;
  logic [DW*4-1:0]  out_a;
  logic [DW*50-1:0] in_b;
  logic [DW*8-1:0]  out_b;
  logic busy_a, done_a, busy_b, done_b;
`ifdef MAXPOOL_ARGMAX_EN
  logic [7:0]  am_a;
  logic [15:0] am_b;
`endif

  maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(1), .IMG_SIZE(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_feature_flat(in_a),
    .out_feature_flat(out_a),
`ifdef MAXPOOL_ARGMAX_EN
    .argmax_flat(am_a),
`endif
    .busy(busy_a), .done(done_a));

  maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(2), .IMG_SIZE(5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_feature_flat(in_b),
    .out_feature_flat(out_b),
`ifdef MAXPOOL_ARGMAX_EN
    .argmax_flat(am_b),
`endif
    .busy(busy_b), .done(done_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk every 2x2 window in the spec's k order, keep first strict maximum.
  task automatic ref_pool(input int c, input int s, input int in_v[$], output int o[$], output int am[$]);
    int os, best, bk, v;
    os = s / 2;
    o = {};
    am = {};
    for (int ch = 0; ch < c; ch++)
      for (int r = 0; r < os; r++)
        for (int cc = 0; cc < os; cc++) begin
          best = in_v[(ch*s + 2*r)*s + 2*cc];
          bk = 0;
          for (int kk = 1; kk < 4; kk++) begin
            v = in_v[(ch*s + 2*r + kk/2)*s + 2*cc + kk%2];
            if (v > best) begin best = v; bk = kk; end
          end
          o.push_back(best);
          am.push_back(bk);
        end
  endtask

  task automatic load(input int sel, input int v[$]);
    for (int i = 0; i < v.size(); i++)
      if (sel == 0) in_a[i*DW +: DW] = DW'(v[i]);
      else          in_b[i*DW +: DW] = DW'(v[i]);
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction

  task automatic set_start(input int sel, input logic val);
    if (sel == 0) start_a = val; else start_b = val;
  endtask

  task automatic check_out(input int sel, input string tag, input int exp_o[$], input int exp_am[$]);
    logic signed [DW-1:0] v;
    for (int j = 0; j < exp_o.size(); j++) begin
      v = (sel == 0) ? out_a[j*DW +: DW] : out_b[j*DW +: DW];
      check($sformatf("%s out[%0d]", tag, j), v, exp_o[j]);
`ifdef MAXPOOL_ARGMAX_EN
      check($sformatf("%s argmax[%0d]", tag, j),
            (sel == 0) ? 32'(am_a[2*j +: 2]) : 32'(am_b[2*j +: 2]), exp_am[j]);
`else
      if (exp_am.size() != exp_o.size()) $display("argmax table size differs for %s", tag);
`endif
    end
  endtask

  // Edge 0 is the edge that samples start; done is observed 1ns after each later edge.
  task automatic run_pass(input int sel, input bit hold, input bit repulse, input int budget,
                          output int first_done, output int second_done, output int n_done);
    first_done = -1; second_done = -1; n_done = 0;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    for (int e = 0; e < budget; e++) begin
      #1;
      if (get_done(sel)) begin
        n_done++;
        if (first_done < 0) first_done = e;
        else if (second_done < 0) second_done = e;
      end
      set_start(sel, hold || (repulse && (e + 1 == 3 || e + 1 == 10)));
      @(posedge clk);
    end
    #1 set_start(sel, 1'b0);
  endtask

  task automatic drain();
    bit idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(posedge clk); #1;
      idle = !busy_a && !done_a && !busy_b && !done_b;
    end
    check("drain to idle", idle, 1);
  endtask

  typedef struct {
    string name;
    int    in_v[16];
    int    exp_o[4];
    int    exp_am[4];
  } vec_t;

  vec_t vecs[3];
  int q_in[$], q_o[$], q_am[$];
  int fd, sd, nd;
  logic signed [15:0] r16;

  initial begin
    vecs[0].name = "ramp";
    vecs[1].name = "const3";
    vecs[2].name = "negramp";
    for (int i = 0; i < 16; i++) begin
      vecs[0].in_v[i] = i;
      vecs[1].in_v[i] = 3;
      vecs[2].in_v[i] = -(i + 1);
    end
    vecs[0].exp_o = '{5, 7, 13, 15};     vecs[0].exp_am = '{3, 3, 3, 3};
    vecs[1].exp_o = '{3, 3, 3, 3};       vecs[1].exp_am = '{0, 0, 0, 0};
    vecs[2].exp_o = '{-1, -3, -9, -11};  vecs[2].exp_am = '{0, 0, 0, 0};

    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; in_a = '0; in_b = '0;
    #22;
    check("reset busy_a", busy_a, 0);
    check("reset done_a", done_a, 0);
    check("reset out_a zero", (out_a == '0), 1);
    check("reset out_b zero", (out_b == '0), 1);
    @(negedge clk) reset = 1'b1;

    foreach (vecs[v]) begin
      q_in = {}; q_o = {}; q_am = {};
      for (int i = 0; i < 16; i++) q_in.push_back(vecs[v].in_v[i]);
      for (int j = 0; j < 4; j++) begin q_o.push_back(vecs[v].exp_o[j]); q_am.push_back(vecs[v].exp_am[j]); end
      load(0, q_in);
      run_pass(0, 0, 0, 20, fd, sd, nd);
      check({vecs[v].name, " done edge"}, fd, 17);
      check({vecs[v].name, " done count"}, nd, 1);
      check({vecs[v].name, " busy after"}, busy_a, 0);
      check_out(0, vecs[v].name, q_o, q_am);
    end

    // start re-pulsed mid-pass must be ignored
    q_in = {}; for (int i = 0; i < 16; i++) q_in.push_back(vecs[0].in_v[i]);
    load(0, q_in);
    run_pass(0, 0, 1, 24, fd, sd, nd);
    check("repulse done edge", fd, 17);
    check("repulse done count", nd, 1);
    q_o = {5, 7, 13, 15}; q_am = {3, 3, 3, 3};
    check_out(0, "repulse", q_o, q_am);

    run_pass(0, 1, 0, 36, fd, sd, nd);
    check("hold first done", fd, 17);
    check("hold second done", sd, 35);
    check("hold done count", nd, 2);
    drain();

    // reset mid-pass aborts with no done
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort busy", busy_a, 0);
    check("abort done", done_a, 0);
    check("abort out zero", (out_a == '0), 1);
    @(negedge clk) reset = 1'b1;
    nd = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk); #1;
      if (done_a) nd++;
    end
    check("abort no done", nd, 0);
    run_pass(0, 0, 0, 20, fd, sd, nd);
    check("restart done edge", fd, 17);
    check("restart done count", nd, 1);
    check_out(0, "restart", q_o, q_am);

    // 2x5x5: row/col 4 never read
    q_in = {};
    for (int i = 0; i < 25; i++) q_in.push_back(i - 12);
    for (int i = 0; i < 25; i++) q_in.push_back((i == 24) ? 100 : 7);
    load(1, q_in);
    run_pass(1, 0, 0, 36, fd, sd, nd);
    check("odd done edge", fd, 33);
    check("odd done count", nd, 1);
    for (int j = 4; j < 8; j++) check($sformatf("odd ch1 out[%0d]", j), $signed(out_b[j*DW +: DW]), 7);
    ref_pool(2, 5, q_in, q_o, q_am);
    check_out(1, "odd model", q_o, q_am);

    for (int t = 0; t < 8; t++) begin
      int sel, n, c, s;
      sel = t % 2;
      n = (sel == 0) ? 16 : 50;
      c = (sel == 0) ? 1 : 2;
      s = (sel == 0) ? 4 : 5;
      q_in = {};
      for (int i = 0; i < n; i++) begin
        if (t >= 4) q_in.push_back(int'($urandom_range(0, 3)) - 2);
        else begin r16 = 16'($urandom()); q_in.push_back(int'(r16)); end
      end
      load(sel, q_in);
      run_pass(sel, 0, 0, 36, fd, sd, nd);
      check($sformatf("rand%0d done edge", t), fd, (sel == 0) ? 17 : 33);
      check($sformatf("rand%0d done count", t), nd, 1);
      ref_pool(c, s, q_in, q_o, q_am);
      check_out(sel, $sformatf("rand%0d", t), q_o, q_am);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxpool2d.md
MAXPOOL2D -- requirements
Module: maxpool2d

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning element width in bits, signed two's complement.
REQ-002 SHALL have parameter CHANNELS, default 8, meaning number of feature-map channels.
REQ-003 SHALL have parameter IMG_SIZE, default 28, meaning input height and width; legal values are 2 or greater.
REQ-004 SHALL define local OUT_SIZE = floor(IMG_SIZE/2) and N_WIN = CHANNELS*OUT_SIZE*OUT_SIZE.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request to pool the whole map once.
REQ-008 SHALL have port in_feature_flat, input, signed DATA_WIDTH x CHANNELS*IMG_SIZE*IMG_SIZE: input map, index (ch*IMG_SIZE+row)*IMG_SIZE+col.
REQ-009 SHALL have port out_feature_flat, output, signed DATA_WIDTH x N_WIN: pooled map, index (ch*OUT_SIZE+orow)*OUT_SIZE+ocol.
REQ-010 SHALL have port busy, output, 1 bit: high while a pass is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port argmax_flat, output, 2 bits x N_WIN, present only under MAXPOOL_ARGMAX_EN: winning window position per output.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and FINISH.
REQ-014 In IDLE, start sampled high SHALL clear the channel, output-row, output-column and phase (k=0..3) counters and enter RUN; otherwise the FSM SHALL remain in IDLE.
REQ-015 RUN SHALL read one input element per cycle, window order k=0:(2r,2c), k=1:(2r,2c+1), k=2:(2r+1,2c), k=3:(2r+1,2c+1).
REQ-016 At k=0 the running max SHALL load the element; at k=1..3 it SHALL replace the running max only if the element is strictly greater (signed compare), so a tie keeps the lowest k.
REQ-017 At k=3 the final max SHALL be written to out_feature_flat at the window's index in the same edge.
REQ-018 Counter order SHALL be: k innermost, then ocol, then orow, then ch. After the last window's k=3, the FSM SHALL enter FINISH.
REQ-019 FINISH SHALL set done=1 and return to IDLE, so done is high for exactly one cycle.
REQ-020 Latency: done SHALL rise 4*N_WIN+1 edges after the edge sampling start.
REQ-021 busy SHALL be high in RUN and FINISH and low in IDLE.
REQ-022 start SHALL be ignored in RUN and FINISH; start held high SHALL begin a new pass on the first IDLE cycle after done.
REQ-023 For odd IMG_SIZE, the last input row and column SHALL never be read.
REQ-024 Output elements not yet written in a pass SHALL hold their previous values.
REQ-025 No arithmetic widening SHALL occur; outputs are exact copies of input elements.

Reset
REQ-026 reset low SHALL asynchronously force state IDLE, done=0, all counters 0, running max 0, every out_feature_flat element 0 and every argmax_flat element 0.
REQ-027 A reset asserted mid-RUN SHALL abort the pass with no done pulse; the next start SHALL restart from window 0.

Configuration
REQ-028 Macro MAXPOOL_ARGMAX_EN, when defined, SHALL add argmax_flat and a running 2-bit argmax register.
REQ-029 Under REQ-028, the argmax register SHALL track the k of the current max (lowest k on ties) and SHALL be written alongside out_feature_flat at k=3.
REQ-030 When MAXPOOL_ARGMAX_EN is undefined, argmax_flat and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 CHANNELS=1, IMG_SIZE=4, input 0..15 row-major, pulse start -> out {5,7,13,15}, argmax {3,3,3,3}, done one cycle, 17 edges after start.
REQ-032 CHANNELS=1, IMG_SIZE=4, all inputs 3 -> out all 3, argmax all 0; all inputs -1..-16 -> out {-1,-3,-9,-11}, argmax all 0.
REQ-033 CHANNELS=2, IMG_SIZE=5, channel 1 filled with 7 except (4,4)=100 -> channel-1 outputs all 7 (row/col 4 ignored), done 33 edges after start.
REQ-034 start re-pulsed at edges 3 and 10 during the REQ-031 pass -> ignored, single done at edge 17; start held high -> second done at edge 35.
REQ-035 reset low at edge 8 of the REQ-031 pass -> immediate IDLE, outputs 0, no done; a fresh start -> correct result, done 17 edges later.
